// File: rtl/terminal_pkg.sv
// terminal_pkg: types and constants shared by the terminal writer and the sprite renderer
package terminal_pkg;
  typedef enum logic {IDLE, CLEAR} tw_state_t;
  localparam logic [7:0] ASCII_SPACE = 8'd32;
  localparam logic [7:0] ASCII_NL = 8'd10;
  localparam logic [7:0] ASCII_BS = 8'd8;
  localparam int DEFAULT_WIDTH = 76;
  localparam int DEFAULT_HEIGHT = 44;
endpackage

// File: rtl/terminal_writer.sv
// terminal_writer: turns an ASCII byte stream into cursor-tracked writes into the terminal grid RAM
module terminal_writer
  import terminal_pkg::*;
#(
  parameter int SCREEN_WIDTH = DEFAULT_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_HEIGHT,
  parameter int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_in,
  input  logic                             char_valid_in,
  input  logic [7:0]                       char_in,
  output logic                             char_ready_out,
  input  logic                             clear_in,
  output logic                             tg_write_en,
  output logic [ADDR_W-1:0]                tg_addr,
  output logic [7:0]                       tg_input,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  cursor_x_out,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] cursor_y_out,
  output logic                             busy_out
);
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  // one spare bit so the sweep can count one past the last cell to signal completion
  localparam int LW = ADDR_W + 1;
  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_HEIGHT - 1);
  localparam logic [LW-1:0] LIN_LAST = LW'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
  localparam logic [LW-1:0] LIN_END = LW'(SCREEN_WIDTH * SCREEN_HEIGHT);
  tw_state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [LW-1:0] lin_q, lin_d, lin_m1;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic accept;
  assign char_ready_out = (state_q == IDLE) && !clear_in && !rst_in;
  assign accept = char_valid_in && char_ready_out;
  assign lin_m1 = lin_q - LW'(1);
  assign tg_write_en = we_q;
  assign tg_addr = addr_q;
  assign tg_input = data_q;
  assign cursor_x_out = x_q;
  assign cursor_y_out = y_q;
  assign busy_out = (state_q == CLEAR);
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    lin_d = lin_q;
    we_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == CLEAR) begin
      if (lin_q == LIN_END) begin
        state_d = IDLE;
        lin_d = '0;
      end else begin
        we_d = 1'b1;
        addr_d = lin_q[ADDR_W-1:0];
        data_d = ASCII_SPACE;
        lin_d = lin_q + LW'(1);
      end
    end else if (clear_in) begin
      // explicit clear emits address 0 right away, so the sweep resumes from 1
      state_d = CLEAR;
      we_d = 1'b1;
      addr_d = '0;
      data_d = ASCII_SPACE;
      lin_d = LW'(1);
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      if (char_in == ASCII_NL) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + YW'(1);
        lin_d = (y_q == Y_MAX) ? '0 : lin_q - LW'(x_q) + LW'(SCREEN_WIDTH);
        state_d = (y_q == Y_MAX) ? CLEAR : IDLE;
      end else if (char_in == ASCII_BS) begin
        if (lin_q != '0) begin
          we_d = 1'b1;
          addr_d = lin_m1[ADDR_W-1:0];
          data_d = ASCII_SPACE;
          lin_d = lin_m1;
          x_d = (x_q != '0) ? x_q - XW'(1) : X_MAX;
          y_d = (x_q != '0) ? y_q : y_q - YW'(1);
        end
      end else begin
        we_d = 1'b1;
        addr_d = lin_q[ADDR_W-1:0];
        data_d = char_in;
        state_d = (lin_q == LIN_LAST) ? CLEAR : IDLE;
        lin_d = (lin_q == LIN_LAST) ? '0 : lin_q + LW'(1);
        x_d = (lin_q == LIN_LAST || x_q == X_MAX) ? '0 : x_q + XW'(1);
        y_d = (lin_q == LIN_LAST) ? '0 : (x_q == X_MAX) ? y_q + YW'(1) : y_q;
      end
    end
  end
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      lin_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      lin_q <= lin_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_terminal_writer.sv
// tb_terminal_writer: scoreboard bench with a cursor-level model of the terminal writer
module tb_terminal_writer;
  localparam int W = 76;
  localparam int H = 44;
  localparam int CELLS = W * H;
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic char_valid_in = 1'b0;
  logic [7:0] char_in = 8'd0;
  logic char_ready_out;
  logic clear_in = 1'b0;
  logic tg_write_en;
  logic [11:0] tg_addr;
  logic [7:0] tg_input;
  logic [6:0] cursor_x_out;
  logic [5:0] cursor_y_out;
  logic busy_out;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int mx = 0;
  int my = 0;
  bit sweep_pending = 0;
  wr_t q[$];
  wr_t e;

  terminal_writer dut (
    .pixel_clk_in(clk),
    .rst_in(rst_in),
    .char_valid_in(char_valid_in),
    .char_in(char_in),
    .char_ready_out(char_ready_out),
    .clear_in(clear_in),
    .tg_write_en(tg_write_en),
    .tg_addr(tg_addr),
    .tg_input(tg_input),
    .cursor_x_out(cursor_x_out),
    .cursor_y_out(cursor_y_out),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (busy_out) busy_cnt++;
    if (tg_write_en) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0d", tg_addr, tg_input);
      end else begin
        e = q.pop_front();
        chk("wr_addr", int'(tg_addr), e.addr);
        chk("wr_data", int'(tg_input), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push_sweep(input int start);
    for (int i = 0; i < CELLS; i++) q.push_back('{i, 32, start + i});
    sweep_pending = 1;
  endtask

  // model works on (x,y) coordinates; the address is computed as y*W+x
  task automatic model_byte(input logic [7:0] b, input int k);
    if (b == 8'd10) begin
      mx = 0;
      if (my == H - 1) begin
        my = 0;
        push_sweep(k + 2);
      end else my++;
    end else if (b == 8'd8) begin
      if (mx > 0) begin
        mx--;
        q.push_back('{my * W + mx, 32, k + 1});
      end else if (my > 0) begin
        mx = W - 1;
        my--;
        q.push_back('{my * W + mx, 32, k + 1});
      end
    end else begin
      q.push_back('{my * W + mx, int'(b), k + 1});
      mx++;
      if (mx == W) begin
        mx = 0;
        my++;
        if (my == H) begin
          my = 0;
          push_sweep(k + 2);
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] c, input bit clr);
    @(negedge clk);
    char_valid_in = v;
    char_in = c;
    clear_in = clr;
    #1;
    chk("ready", int'(char_ready_out), clr ? 0 : 1);
    if (clr) begin
      mx = 0;
      my = 0;
      push_sweep(cyc + 1);
    end else if (v) model_byte(c, cyc);
    @(posedge clk);
    #1;
    chk("cursor_x", int'(cursor_x_out), mx);
    chk("cursor_y", int'(cursor_y_out), my);
    char_valid_in = 1'b0;
    clear_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < CELLS + 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", int'(busy_out), 0);
    chk("sweep_drained", q.size(), 0);
    sweep_pending = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b1;
    char_valid_in = 1'b0;
    clear_in = 1'b0;
    #1;
    chk("ready_in_reset", int'(char_ready_out), 0);
    @(posedge clk);
    #1;
    chk("rst_we", int'(tg_write_en), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_addr", int'(tg_addr), 0);
    chk("rst_data", int'(tg_input), 0);
    chk("rst_cx", int'(cursor_x_out), 0);
    chk("rst_cy", int'(cursor_y_out), 0);
    q.delete();
    mx = 0;
    my = 0;
    sweep_pending = 0;
    @(negedge clk);
    rst_in = 1'b0;
    #1;
    chk("ready_after_reset", int'(char_ready_out), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    do_reset();
    step(1, 8'd97, 0);
    step(1, 8'd98, 0);
    step(0, 8'd0, 0);
    do_reset();
    for (int i = 0; i < 75; i++) step(1, 8'(33 + i), 0);
    step(1, 8'd122, 0);
    step(0, 8'd0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'd10, 0);
    for (int i = 0; i < 5; i++) step(1, 8'd120, 0);
    step(1, 8'd10, 0);
    step(1, 8'd8, 0);
    step(0, 8'd0, 0);
    do_reset();
    step(1, 8'd8, 0);
    step(0, 8'd0, 0);
    busy_cnt = 0;
    step(1, 8'd120, 1);
    wait_idle();
    chk("clear_busy_cycles", busy_cnt, CELLS);
    step(1, 8'd65, 0);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      b = 8'($urandom_range(32, 126));
      if (r < 10) step(1, 8'd10, 0);
      else if (r < 25) step(1, 8'd8, 0);
      else if (r < 26) step(0, 8'd0, 1);
      else if (r < 35) step(0, 8'd0, 0);
      else if (r < 40) step(1, 8'($urandom_range(0, 255)) | 8'h80, 0);
      else step(1, b, 0);
      if (sweep_pending) wait_idle();
    end
    step(0, 8'd0, 0);
    chk("random_drained", q.size(), 0);
    do_reset();
    for (int i = 0; i < CELLS - 1; i++) step(1, 8'(65 + i % 26), 0);
    busy_cnt = 0;
    step(1, 8'd90, 0);
    wait_idle();
    chk("auto_busy_cycles", busy_cnt, CELLS + 1);
    step(1, 8'd49, 0);
    step(0, 8'd0, 1);
    repeat (100) @(posedge clk);
    do_reset();
    step(1, 8'd50, 0);
    step(0, 8'd0, 0);
    chk("final_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/terminal_writer.md
# terminal_writer

Upstream producer for the character sprite renderer's terminal-grid write port. Accepts a stream of ASCII bytes over a valid/ready handshake, tracks a text cursor, and issues single-cycle writes (`tg_write_en`/`tg_addr`/`tg_input`) into the grid RAM. It handles newline, backspace, end-of-screen wrap and a full-screen clear sweep.

## Interface
Parameters:
- `SCREEN_WIDTH`, default 76: columns.
- `SCREEN_HEIGHT`, default 44: rows.
- `ADDR_W`, default `$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)` (12): grid address width.

Ports:
- `pixel_clk_in`  in  1  sole clock.
- `rst_in`  in  1  reset. One clock; reset is synchronous and active-high.
- `char_valid_in`  in  1  `char_in` holds a byte.
- `char_in`  in  8  ASCII byte.
- `char_ready_out`  out  1  block can accept a byte this cycle.
- `clear_in`  in  1  single-cycle request to blank the screen.
- `tg_write_en`  out  1  grid write strobe.
- `tg_addr`  out  ADDR_W  grid address, row-major (`y*SCREEN_WIDTH + x`).
- `tg_input`  out  8  byte to write.
- `cursor_x_out`  out  `$clog2(SCREEN_WIDTH)`  current column.
- `cursor_y_out`  out  `$clog2(SCREEN_HEIGHT)`  current row.
- `busy_out`  out  1  clear sweep in progress.

## Operation
- States: IDLE and CLEAR.
- `char_ready_out = (state==IDLE) && !clear_in && !rst_in`. A byte is accepted when valid && ready.
- Cursor state is x, y and a linear address register `lin`. `lin` is updated incrementally; no multiplier.
- Accepted byte 10 (newline):
  - No write is issued.
  - x←0, y←y+1, `lin` moves to the next row start.
  - If y was `SCREEN_HEIGHT-1`, go to CLEAR.
- Accepted byte 8 (backspace):
  - If x>0: x←x−1, then write 32 at the new position.
  - Else if y>0: x←`SCREEN_WIDTH-1`, y←y−1, then write 32 there.
  - At (0,0): no write, no move.
- Any other accepted byte:
  - Written unchanged at `lin`. Unmapped codes render blank downstream.
  - Then x←x+1. At x=`SCREEN_WIDTH-1` instead x←0, y←y+1.
  - Advancing past the last cell (`lin`=W*H−1) enters CLEAR.
- CLEAR:
  - Sweeps address 0..W*H−1, one write of 32 per cycle.
  - Cursor is held at (0,0) throughout. Return to IDLE after the last write.
- `clear_in` in IDLE enters CLEAR immediately. A simultaneous valid byte is not accepted, because ready is low.
- `clear_in` during CLEAR is ignored; the sweep is not restarted.
- `busy_out` is high exactly while in CLEAR.

## Timing
- Reset values:
  - `tg_write_en`=0, `tg_addr`=0, `tg_input`=0.
  - Cursor (0,0), `lin`=0.
  - `busy_out`=0, state IDLE.
  - `char_ready_out`=0 while `rst_in` is high, then 1 on the first cycle after.
- All grid outputs are registered. A byte accepted in cycle N produces `tg_write_en`=1 with its address and data in cycle N+1, for exactly one cycle.
- Back-to-back accepts produce back-to-back writes at full throughput.
- Cursor outputs reflect the post-update position in cycle N+1.
- Auto-clear after the last cell or last-row newline:
  - The final character write (if any) occurs in N+1.
  - `busy_out` rises in N+1.
  - The sweep writes address 0 in N+2 and address W*H−1 in N+1+W*H.
  - `char_ready_out` returns in N+2+W*H.
- Explicit `clear_in` in cycle N: the address-0 write is in N+1, the last write in N+W*H, IDLE in N+W*H+1.
- Reset mid-sweep:
  - The next cycle has `tg_write_en`=0 and state IDLE.
  - Grid contents stay partially cleared; this is accepted.
- Every write steals the display's read of the shared grid port for one pixel. This one-pixel artifact is accepted.

## Structure
- Shared package `terminal_pkg` holds:
  - The state typedef `tw_state_t` {IDLE, CLEAR}.
  - Constants `ASCII_SPACE`=32, `ASCII_NL`=10, `ASCII_BS`=8.
  - Default screen dimensions, shared with the renderer.
- Flat module; no sub-module is warranted. Cursor and sweep logic share the `lin` counter.

## Test plan
- Reset, then send "ab" on consecutive cycles -> writes (addr 0, 97) and (addr 1, 98) on consecutive cycles; cursor ends at (2,0).
- Send 75 bytes then 'z' -> 'z' written at addr 75; cursor becomes (0,1), `lin`=76.
- At (5,3), send 10 then 8 -> no write for the newline, cursor (0,4); backspace writes 32 at addr 3*76+75=303; cursor (75,3).
- Backspace at (0,0) -> no write, cursor stays (0,0), ready stays high.
- Pulse `clear_in` with a valid byte present -> byte not accepted; 3344 writes of 32 covering addresses 0..3343; `busy_out` high for exactly 3344 cycles; cursor (0,0).
- Fill all 3344 cells -> last write at addr 3343, then the auto-clear sweep runs. Separately, assert reset mid-sweep -> `tg_write_en`=0 the next cycle and ready returns after reset releases.
